uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
Byte-level packet deframer placed directly downstream of the UART receiver. It consumes the receiver's one-cycle data-valid strobe and byte, hunts for a sync byte, and parses a length-prefixed, checksummed frame into an internal payload buffer. A good frame is presented to the system as a readable packet with valid/read-enable handshaking. Bad frames are discarded, and a one-cycle error pulse is raised for each one.

Parameters:
MAX_LEN, 16, maximum payload length in bytes (buffer depth); valid range 1..255
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 1000, maximum idle clocks between bytes inside a frame before abort; must be below 2^16

Ports:
i_Clock  in  1  system clock, same domain as the UART receiver
i_Reset  in  1  synchronous, active-high reset
i_Rx_DV  in  1  one-cycle byte strobe from the UART receiver
i_Rx_Byte  in  8  received byte, qualified by i_Rx_DV
o_Pkt_Valid  out  1  good packet held; o_Data is valid
o_Pkt_Len  out  8  payload length of the held packet
o_Data  out  8  current payload byte (buf[rd_ptr])
o_Pkt_Last  out  1  o_Data is the final payload byte
i_Rd_En  in  1  consume o_Data; ignored unless o_Pkt_Valid is high
o_Err_Chk  out  1  one-cycle pulse: checksum failure
o_Err_Len  out  1  one-cycle pulse: length 0 or greater than MAX_LEN
o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout
o_Drop  out  1  one-cycle pulse: byte arrived while a packet was held, byte discarded

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock port is i_Clock and the reset port is i_Reset.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK. A frame is good when (LEN + sum of payload + CHK) mod 256 == 0, using an 8-bit wrapping accumulator.
- Reset values: state=HUNT. o_Pkt_Valid, o_Pkt_Last and all error/drop pulses = 0. o_Pkt_Len=0, o_Data=0. rd_ptr, wr_ptr, accumulator and timeout counter = 0.
- Bytes are acted on only in cycles where i_Rx_DV=1.
- FSM states and transitions:
  - HUNT: SYNC_BYTE -> LEN. Any other byte is ignored silently (no error).
  - LEN: store LEN and set acc=LEN, wr_ptr=0.
    - LEN=0 or LEN>MAX_LEN -> pulse o_Err_Len, go to HUNT.
    - Otherwise -> PAYLOAD.
  - PAYLOAD: write buf[wr_ptr]=byte, acc+=byte, wr_ptr++. After the byte where wr_ptr reaches LEN -> CHKSUM.
  - CHKSUM: if acc+byte==0 -> HOLD with rd_ptr=0. Otherwise pulse o_Err_Chk and go to HUNT.
  - HOLD: o_Pkt_Valid=1, o_Data=buf[rd_ptr], o_Pkt_Last=(rd_ptr==LEN-1).
    - i_Rd_En with o_Pkt_Last=0: rd_ptr++.
    - i_Rd_En with o_Pkt_Last=1: next cycle go to HUNT, o_Pkt_Valid=0.
- Latency: o_Pkt_Valid rises on the clock after the cycle in which the CHK byte strobe is sampled. Error pulses appear on the clock after the offending byte (or timeout) and last exactly one cycle.
- Timeout: in LEN, PAYLOAD and CHKSUM the counter increments every clock and clears on every i_Rx_DV. When it reaches TIMEOUT_CLKS-1 without a strobe: pulse o_Err_Timeout, go to HUNT, discard the partial frame. No timeout applies in HUNT or HOLD.
- HOLD does not accept input. Any i_Rx_DV in HOLD pulses o_Drop and the byte is discarded, including a SYNC_BYTE; the FSM does not re-hunt until the packet is drained.
- A SYNC_BYTE value inside LEN, PAYLOAD or CHKSUM is treated as data, not as a resync.
- i_Rd_En while o_Pkt_Valid=0 has no effect.
- The final i_Rd_En and a new i_Rx_DV in the same cycle: the byte is dropped (o_Drop pulses), because the state is still HOLD.
- o_Pkt_Len holds the last good length until the next good frame enters HOLD.
- i_Reset at any point, including mid-frame or mid-drain, returns all state to reset values on the next clock. The buffer contents are don't-care after reset.

Test Plan:
- Good frame: strobes A5 03 10 20 30 9D -> o_Pkt_Valid=1 one cycle after 9D, o_Pkt_Len=3. Three i_Rd_En pulses read out 10, 20, 30; o_Pkt_Last is high only with 30; o_Pkt_Valid=0 after the last read.
- Checksum error: A5 03 10 20 30 9C -> single-cycle o_Err_Chk, o_Pkt_Valid stays 0. A following good frame A5 01 7F 80 is delivered with payload 7F.
- Length errors: A5 00 -> o_Err_Len. A5 11 with MAX_LEN=16 -> o_Err_Len. Next byte 05 in HUNT is ignored with no error.
- Timeout: A5 02 44, then no strobe for TIMEOUT_CLKS clocks -> one o_Err_Timeout pulse, return to HUNT. A fresh A5 01 7F 80 is delivered correctly.
- Hold/drop: deliver A5 01 7F 80 without asserting i_Rd_En, then strobe A5 and 33 -> two o_Drop pulses, o_Data stays 7F. After the read, A5 01 7F 80 is accepted normally.
- Reset mid-frame: A5 03 10, then i_Reset for 1 cycle -> all outputs 0. Then A5 01 7F 80 -> packet 7F delivered, no stale bytes.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// Byte-level deframer behind the UART receiver: hunts SYNC_BYTE, parses LEN/payload/CHK,
// holds a good packet for read-out and pulses one error flag per discarded frame.
module uart_rx_deframer #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pkt_Valid,
    output logic [7:0] o_Pkt_Len,
    output logic [7:0] o_Data,
    output logic       o_Pkt_Last,
    input  logic       i_Rd_En,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Drop
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << AW;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHKSUM  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // 8-bit wrapping checksum accumulate
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // A frame is good when length + payload + check byte wraps to zero
    function automatic logic chk_ok(input logic [7:0] acc, input logic [7:0] chk);
        return (chk_add(acc, chk) == 8'd0);
    endfunction

    state_t      state_r;
    logic [7:0]  len_r;
    logic [7:0]  acc_r;
    logic [7:0]  wr_ptr_r;
    logic [7:0]  rd_ptr_r;
    logic [15:0] tmo_cnt_r;
    logic [7:0]  buf_r [0:DEPTH-1];

    logic        in_frame_s;
    logic        tmo_hit_s;
    logic        len_bad_s;
    logic [7:0]  wr_nxt_s;
    logic [7:0]  rd_nxt_s;

    assign in_frame_s = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHKSUM);
    assign tmo_hit_s  = in_frame_s && !i_Rx_DV && (tmo_cnt_r == TMO_LAST);
    assign len_bad_s  = (i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B);
    assign wr_nxt_s   = wr_ptr_r + 8'd1;
    assign rd_nxt_s   = rd_ptr_r + 8'd1;

    // Payload storage; contents are don't-care after reset so it carries no reset
    always_ff @(posedge i_Clock) begin
        if ((state_r == ST_PAYLOAD) && i_Rx_DV) begin
            buf_r[wr_ptr_r[AW-1:0]] <= i_Rx_Byte;
        end
    end

    // Frame FSM with registered handshake, data and pulse outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r       <= ST_HUNT;
            len_r         <= 8'd0;
            acc_r         <= 8'd0;
            wr_ptr_r      <= 8'd0;
            rd_ptr_r      <= 8'd0;
            tmo_cnt_r     <= 16'd0;
            o_Pkt_Valid   <= 1'b0;
            o_Pkt_Len     <= 8'd0;
            o_Data        <= 8'd0;
            o_Pkt_Last    <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Drop        <= 1'b0;
        end else begin
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Drop        <= 1'b0;

            // Idle counter only runs while a frame is partially received
            if (in_frame_s && !i_Rx_DV && !tmo_hit_s) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= 16'd0;
            end

            case (state_r)
                ST_HUNT: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_r <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (i_Rx_DV) begin
                        len_r    <= i_Rx_Byte;
                        acc_r    <= i_Rx_Byte;
                        wr_ptr_r <= 8'd0;
                        if (len_bad_s) begin
                            o_Err_Len <= 1'b1;
                            state_r   <= ST_HUNT;
                        end else begin
                            state_r   <= ST_PAYLOAD;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Timeout <= 1'b1;
                        state_r       <= ST_HUNT;
                    end
                end

                ST_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        acc_r    <= chk_add(acc_r, i_Rx_Byte);
                        wr_ptr_r <= wr_nxt_s;
                        if (wr_nxt_s == len_r) begin
                            state_r <= ST_CHKSUM;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Timeout <= 1'b1;
                        state_r       <= ST_HUNT;
                    end
                end

                ST_CHKSUM: begin
                    if (i_Rx_DV) begin
                        if (chk_ok(acc_r, i_Rx_Byte)) begin
                            state_r     <= ST_HOLD;
                            rd_ptr_r    <= 8'd0;
                            o_Pkt_Valid <= 1'b1;
                            o_Pkt_Len   <= len_r;
                            o_Data      <= buf_r[0];
                            o_Pkt_Last  <= (len_r == 8'd1);
                        end else begin
                            o_Err_Chk <= 1'b1;
                            state_r   <= ST_HUNT;
                        end
                    end else if (tmo_hit_s) begin
                        o_Err_Timeout <= 1'b1;
                        state_r       <= ST_HUNT;
                    end
                end

                ST_HOLD: begin
                    // Incoming bytes are never buffered while a packet is held
                    if (i_Rx_DV) begin
                        o_Drop <= 1'b1;
                    end
                    if (i_Rd_En) begin
                        if (o_Pkt_Last) begin
                            state_r     <= ST_HUNT;
                            rd_ptr_r    <= 8'd0;
                            o_Pkt_Valid <= 1'b0;
                            o_Pkt_Last  <= 1'b0;
                            o_Data      <= 8'd0;
                        end else begin
                            rd_ptr_r    <= rd_nxt_s;
                            o_Data      <= buf_r[rd_nxt_s[AW-1:0]];
                            o_Pkt_Last  <= (rd_nxt_s == (len_r - 8'd1));
                        end
                    end
                end

                default: begin
                    state_r <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised scoreboard bench for uart_rx_deframer: stimulus pushes expected events and
// bytes derived from frame arithmetic; a negedge monitor pops and compares them.
module tb_uart_rx_deframer;

    localparam int         MAXL = 16;
    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int EV_PKT = 0, EV_CHK = 1, EV_LEN = 2, EV_TMO = 3, EV_DROP = 4;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'd0;
    logic       i_Rd_En = 1'b0;
    logic       o_Pkt_Valid, o_Pkt_Last, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop;
    logic [7:0] o_Pkt_Len, o_Data;

    uart_rx_deframer #(.MAX_LEN(MAXL), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .o_Pkt_Valid(o_Pkt_Valid), .o_Pkt_Len(o_Pkt_Len), .o_Data(o_Data),
        .o_Pkt_Last(o_Pkt_Last), .i_Rd_En(i_Rd_En), .o_Err_Chk(o_Err_Chk),
        .o_Err_Len(o_Err_Len), .o_Err_Timeout(o_Err_Timeout), .o_Drop(o_Drop)
    );

    always #5 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int         ev_code_q[$];
    int         ev_cyc_q[$];
    int         ev_len_q[$];
    logic [7:0] byte_q[$];
    logic       last_q[$];
    logic [7:0] pl_q[$];
    int         last_edge = 0;

    // ---------------- monitor ----------------
    logic prev_valid   = 1'b0;
    logic fall_pending = 1'b0;

    task automatic check_event(input int code);
        int ec, ecy, el;
        total++;
        if (ev_code_q.size() == 0) begin
            bad++;
            $display("FAIL event: got code=%0d at cyc=%0d, expected no event", code, cyc);
        end else begin
            ec = ev_code_q.pop_front(); ecy = ev_cyc_q.pop_front(); el = ev_len_q.pop_front();
            if (code != ec || cyc != ecy || (code == EV_PKT && int'(o_Pkt_Len) != el)) begin
                bad++;
                $display("FAIL event: got code=%0d cyc=%0d len=%0d, expected code=%0d cyc=%0d len=%0d",
                         code, cyc, o_Pkt_Len, ec, ecy, el);
            end
        end
    endtask

    always @(negedge i_Clock) begin
        logic [7:0] eb;
        logic       elast;
        if (fall_pending) begin
            total++;
            if (o_Pkt_Valid !== 1'b0) begin
                bad++;
                $display("FAIL valid_fall: got %0b expected 0", o_Pkt_Valid);
            end
            fall_pending = 1'b0;
        end
        if (o_Pkt_Valid && !prev_valid) check_event(EV_PKT);
        if (o_Err_Chk)     check_event(EV_CHK);
        if (o_Err_Len)     check_event(EV_LEN);
        if (o_Err_Timeout) check_event(EV_TMO);
        if (o_Drop)        check_event(EV_DROP);
        if (o_Pkt_Valid && i_Rd_En) begin
            total++;
            if (byte_q.size() == 0) begin
                bad++;
                $display("FAIL read: got data=%0h with no byte expected", o_Data);
            end else begin
                eb = byte_q.pop_front(); elast = last_q.pop_front();
                if (o_Data !== eb || o_Pkt_Last !== elast) begin
                    bad++;
                    $display("FAIL read: got data=%0h last=%0b expected data=%0h last=%0b",
                             o_Data, o_Pkt_Last, eb, elast);
                end
                if (elast) fall_pending = 1'b1;
            end
        end
        prev_valid = o_Pkt_Valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge i_Clock); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        i_Rx_DV = 1'b1; i_Rx_Byte = b;
        @(posedge i_Clock); #1;
        i_Rx_DV = 1'b0;
        last_edge = cyc;
    endtask

    task automatic push_ev(input int code, input int c, input int len);
        ev_code_q.push_back(code); ev_cyc_q.push_back(c); ev_len_q.push_back(len);
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap == 0) return 0;
        if ($urandom_range(0, 15) == 0) return TMO - 1;
        return int'($urandom_range(0, maxgap));
    endfunction

    function automatic logic [7:0] chk_for(input int len);
        int s = len;
        for (int i = 0; i < len; i++) s += int'(pl_q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic fill(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends a whole frame; expectations come from the frame arithmetic alone
    task automatic do_frame(input logic [7:0] len, input logic [7:0] chk, input int maxgap,
                            output int got_len);
        int s;
        got_len = 0;
        send(SYNC); idle(pick_gap(maxgap)); send(len);
        if (len == 8'd0 || int'(len) > MAXL) begin
            push_ev(EV_LEN, last_edge, 0);
            return;
        end
        s = int'(len);
        for (int i = 0; i < int'(len); i++) begin
            idle(pick_gap(maxgap)); send(pl_q[i]); s += int'(pl_q[i]);
        end
        idle(pick_gap(maxgap)); send(chk); s += int'(chk);
        if (s % 256 == 0) begin
            push_ev(EV_PKT, last_edge, int'(len));
            for (int i = 0; i < int'(len); i++) begin
                byte_q.push_back(pl_q[i]); last_q.push_back(i == int'(len) - 1);
            end
            got_len = int'(len);
        end else begin
            push_ev(EV_CHK, last_edge, 0);
        end
    endtask

    task automatic drain(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(0, maxgap)));
            i_Rd_En = 1'b1; @(posedge i_Clock); #1; i_Rd_En = 1'b0;
        end
    endtask

    task automatic good_7f(input int maxgap);
        int gl;
        pl_q.delete(); pl_q.push_back(8'h7F);
        do_frame(8'd1, 8'h80, maxgap, gl);
        drain(gl, maxgap);
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({o_Pkt_Valid, o_Pkt_Last, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop} !== 6'd0 ||
            o_Pkt_Len !== 8'd0 || o_Data !== 8'd0) begin
            bad++;
            $display("FAIL %s: got valid=%0b last=%0b errs=%0b%0b%0b drop=%0b len=%0h data=%0h expected all 0",
                     name, o_Pkt_Valid, o_Pkt_Last, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop,
                     o_Pkt_Len, o_Data);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        total++; bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int gl, kind, n, k;
        logic [7:0] b, ln;

        idle(3); i_Reset = 1'b0;
        check_idle_outputs("reset_state");

        // Reference good frame A5 03 10 20 30 9D
        pl_q = '{8'h10, 8'h20, 8'h30};
        do_frame(8'd3, 8'h9D, 0, gl); drain(gl, 2);

        // Checksum error then good frame
        pl_q = '{8'h10, 8'h20, 8'h30};
        do_frame(8'd3, 8'h9C, 0, gl);
        good_7f(0);

        // Length errors then a non-sync byte ignored in hunt
        do_frame(8'd0, 8'd0, 0, gl);
        do_frame(8'h11, 8'd0, 0, gl);
        send(8'h05); idle(3);

        // Maximum length frame
        fill(MAXL); do_frame(8'(MAXL), chk_for(MAXL), 2, gl); drain(gl, 1);

        // Timeout after a partial frame, then recovery
        send(SYNC); send(8'h02); send(8'h44);
        push_ev(EV_TMO, last_edge + TMO, 0);
        idle(TMO + 3);
        good_7f(0);

        // Gaps of TMO-1 idle clocks are still inside the window
        send(SYNC); idle(TMO - 1); send(8'h01); idle(TMO - 1); send(8'h7F); idle(TMO - 1); send(8'h80);
        push_ev(EV_PKT, last_edge, 1); byte_q.push_back(8'h7F); last_q.push_back(1'b1);
        drain(1, 0);

        // Bytes arriving while a packet is held are dropped, even a sync byte
        pl_q.delete(); pl_q.push_back(8'h7F);
        do_frame(8'd1, 8'h80, 0, gl);
        send(SYNC); push_ev(EV_DROP, last_edge, 0);
        send(8'h33); push_ev(EV_DROP, last_edge, 0);
        idle(2); drain(gl, 0);
        good_7f(1);

        // Final read coinciding with a byte strobe still drops that byte
        pl_q = '{8'h5A, 8'hC3};
        do_frame(8'd2, chk_for(2), 0, gl);
        drain(1, 1);
        i_Rd_En = 1'b1; i_Rx_DV = 1'b1; i_Rx_Byte = SYNC;
        @(posedge i_Clock); #1;
        i_Rd_En = 1'b0; i_Rx_DV = 1'b0;
        push_ev(EV_DROP, cyc, 0);
        good_7f(0);

        // Reset in the middle of a frame
        send(SYNC); send(8'h03); send(8'h10);
        i_Reset = 1'b1; @(posedge i_Clock); #1; i_Reset = 1'b0;
        check_idle_outputs("reset_midframe");
        good_7f(0);

        // Randomised mix
        for (int it = 0; it < 80; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                n = int'($urandom_range(1, MAXL));
                fill(n); do_frame(8'(n), chk_for(n), 4, gl);
                k = int'($urandom_range(0, 2));
                for (int d = 0; d < k; d++) begin
                    idle(int'($urandom_range(0, 3)));
                    send(8'($urandom_range(0, 255))); push_ev(EV_DROP, last_edge, 0);
                end
                drain(gl, 3);
            end else if (kind == 6) begin
                n = int'($urandom_range(1, MAXL));
                fill(n); do_frame(8'(n), chk_for(n) + 8'($urandom_range(1, 255)), 4, gl);
            end else if (kind == 7) begin
                ln = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
                do_frame(ln, 8'd0, 4, gl);
            end else if (kind == 8) begin
                n = int'($urandom_range(1, MAXL));
                k = int'($urandom_range(0, n + 1));
                send(SYNC);
                if (k > 0) send(8'(n));
                for (int i = 1; i < k; i++) send(8'($urandom_range(0, 255)));
                push_ev(EV_TMO, last_edge + TMO, 0);
                idle(TMO + 2);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == SYNC) b = 8'h00;
                    send(b);
                end
                i_Rd_En = 1'b1; @(posedge i_Clock); #1; i_Rd_En = 1'b0;
            end
            idle(int'($urandom_range(0, 3)));
        end

        idle(5);
        total++;
        if (ev_code_q.size() != 0 || byte_q.size() != 0) begin
            bad++;
            $display("FAIL leftovers: got events=%0d bytes=%0d pending, expected 0 and 0",
                     ev_code_q.size(), byte_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
